// File: rtl/aclk_pkg.sv
// aclk_pkg
//   Shared types and constants for the alarm-clock alarm bank and any other
//   block that handles BCD HH:MM times (e.g. the clock-set path).
//   - aclk_state_e : ringer state (IDLE, RING, SNOOZE)
//   - digit limits : largest legal value of each BCD digit
//   - bcd_hhmm_t   : packed HH:MM time, one 4-bit BCD digit per field
package aclk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } aclk_state_e;

    // Largest legal value of each digit. The hour units digit is capped at
    // 3 when the hour tens digit is 2, which keeps hours at 23 or below.
    localparam logic [3:0] MS_HR_MAX      = 4'd2;
    localparam logic [3:0] LS_HR_MAX      = 4'd9;
    localparam logic [3:0] LS_HR_MAX_TOP  = 4'd3;
    localparam logic [3:0] MS_MIN_MAX     = 4'd5;
    localparam logic [3:0] LS_MIN_MAX     = 4'd9;

    // Ring and snooze counters only need to reach 15 minute ticks.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_hhmm_t;

endpackage

// File: rtl/aclk_bcd_time_check.sv
// aclk_bcd_time_check
//   Combinational validity check of a BCD HH:MM time (00:00 .. 23:59).
//   Ports:
//     time_i  : BCD time to check
//     valid_o : 1 when every digit is in range and the hour is at most 23
module aclk_bcd_time_check
    import aclk_pkg::*;
(
    input  bcd_hhmm_t time_i,
    output logic      valid_o
);

    logic hr_ok;
    logic min_ok;

    always_comb begin
        hr_ok = 1'b0;
        if (time_i.ms_hr < MS_HR_MAX) begin
            hr_ok = (time_i.ls_hr <= LS_HR_MAX);
        end else if (time_i.ms_hr == MS_HR_MAX) begin
            hr_ok = (time_i.ls_hr <= LS_HR_MAX_TOP);
        end
        min_ok  = (time_i.ms_min <= MS_MIN_MAX) && (time_i.ls_min <= LS_MIN_MAX);
        valid_o = hr_ok && min_ok;
    end

endmodule

// File: rtl/aclk_alarm_bank.sv
// aclk_alarm_bank
//   Multi-slot alarm store and ringer. Holds NUM_ALARMS BCD HH:MM alarm
//   times with individual arm bits, compares them against the current time
//   on every minute tick while idle, and drives a ringing output with
//   snooze, stop and automatic timeout.
//   Ports:
//     clk, reset           : clock, asynchronous active-high reset
//     load_new_a           : write request; load_slot / load_arm / new_alarm_*
//                            give the target slot, arm bit and BCD time
//     cur_*                : current BCD time, valid with minute_tick
//     minute_tick          : one-cycle pulse per new minute
//     snooze, stop         : user pulses acting on the ringer
//     disp_slot            : slot selected for readback
//     alarm, alarm_id      : ringing flag and slot that caused the ring
//     load_err             : one-cycle pulse after a rejected load
//     disp_*, disp_armed   : registered readback of disp_slot
module aclk_alarm_bank
    import aclk_pkg::*;
#(
    parameter  int NUM_ALARMS = 4,
    parameter  int SNOOZE_MIN = 5,
    parameter  int RING_MIN   = 10,
    localparam int SLOT_W     = $clog2(NUM_ALARMS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_new_a,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic              load_arm,
    input  logic [3:0]        new_alarm_ms_hr,
    input  logic [3:0]        new_alarm_ls_hr,
    input  logic [3:0]        new_alarm_ms_min,
    input  logic [3:0]        new_alarm_ls_min,
    input  logic [3:0]        cur_ms_hr,
    input  logic [3:0]        cur_ls_hr,
    input  logic [3:0]        cur_ms_min,
    input  logic [3:0]        cur_ls_min,
    input  logic              minute_tick,
    input  logic              snooze,
    input  logic              stop,
    input  logic [SLOT_W-1:0] disp_slot,
    output logic              alarm,
    output logic [SLOT_W-1:0] alarm_id,
    output logic              load_err,
    output logic [3:0]        disp_ms_hr,
    output logic [3:0]        disp_ls_hr,
    output logic [3:0]        disp_ms_min,
    output logic [3:0]        disp_ls_min,
    output logic              disp_armed
);

    localparam logic [CNT_W-1:0] SNOOZE_LIM = CNT_W'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] RING_LIM   = CNT_W'(RING_MIN);

    // ------------------------------------------------------------------
    // Slot storage and load path
    // ------------------------------------------------------------------
    bcd_hhmm_t [NUM_ALARMS-1:0] slot_q;
    logic      [NUM_ALARMS-1:0] armed_q;

    bcd_hhmm_t new_time;
    bcd_hhmm_t cur_time;
    logic      new_time_ok;
    logic      load_slot_ok;
    logic      load_ok;
    logic      load_err_q;

    assign new_time = '{ms_hr:  new_alarm_ms_hr,  ls_hr:  new_alarm_ls_hr,
                        ms_min: new_alarm_ms_min, ls_min: new_alarm_ls_min};
    assign cur_time = '{ms_hr:  cur_ms_hr,  ls_hr:  cur_ls_hr,
                        ms_min: cur_ms_min, ls_min: cur_ls_min};

    aclk_bcd_time_check u_new_chk (
        .time_i  (new_time),
        .valid_o (new_time_ok)
    );

    // Only matters when NUM_ALARMS is not a power of two.
    assign load_slot_ok = (int'(load_slot) < NUM_ALARMS);
    assign load_ok      = load_new_a && new_time_ok && load_slot_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q     <= '0;
            armed_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_new_a && !load_ok;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (load_ok && (int'(load_slot) == i)) begin
                    slot_q[i]  <= new_time;
                    armed_q[i] <= load_arm;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Parallel compare + lowest-index priority encoder. Uses registered
    // slot contents, so a load landing on the tick edge is not seen.
    // ------------------------------------------------------------------
    logic [NUM_ALARMS-1:0] match;
    logic [SLOT_W-1:0]     first_idx;

    always_comb begin
        match     = '0;
        first_idx = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i] = armed_q[i] && (slot_q[i] == cur_time);
        end
        // Descending scan so the lowest matching index is written last.
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (match[i]) begin
                first_idx = SLOT_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Ringer state machine
    // ------------------------------------------------------------------
    aclk_state_e       state_q, state_d;
    logic [CNT_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic [SLOT_W-1:0] id_q, id_d;
    logic              alarm_q;
    logic [CNT_W-1:0]  ring_inc;
    logic [CNT_W-1:0]  snz_inc;

    assign ring_inc = ring_cnt_q + 1'b1;
    assign snz_inc  = snz_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        id_d       = id_q;
        unique case (state_q)
            IDLE: begin
                if (minute_tick && (|match)) begin
                    state_d    = RING;
                    ring_cnt_d = '0;
                    id_d       = first_idx;
                end
            end
            RING: begin
                // stop > snooze > minute_tick; a tick lost to snooze is not counted.
                if (stop) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = '0;
                end else if (minute_tick) begin
                    ring_cnt_d = ring_inc;
                    if (ring_inc == RING_LIM) begin
                        state_d = IDLE;
                    end
                end
            end
            SNOOZE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (minute_tick) begin
                    snz_cnt_d = snz_inc;
                    if (snz_inc == SNOOZE_LIM) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            id_q       <= '0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            id_q       <= id_d;
            alarm_q    <= (state_d == RING);
        end
    end

    // ------------------------------------------------------------------
    // Registered readback
    // ------------------------------------------------------------------
    bcd_hhmm_t disp_q;
    logic      disp_armed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q       <= '0;
            disp_armed_q <= 1'b0;
        end else if (int'(disp_slot) < NUM_ALARMS) begin
            disp_q       <= slot_q[disp_slot];
            disp_armed_q <= armed_q[disp_slot];
        end else begin
            disp_q       <= '0;
            disp_armed_q <= 1'b0;
        end
    end

    assign alarm       = alarm_q;
    assign alarm_id    = id_q;
    assign load_err    = load_err_q;
    assign disp_ms_hr  = disp_q.ms_hr;
    assign disp_ls_hr  = disp_q.ls_hr;
    assign disp_ms_min = disp_q.ms_min;
    assign disp_ls_min = disp_q.ls_min;
    assign disp_armed  = disp_armed_q;

endmodule

// File: tb/tb_aclk_alarm_bank.sv
// Scoreboard bench for aclk_alarm_bank. The driver applies one cycle of
// stimulus at a time, predicts the outputs after the next clock edge with a
// behavioural model (times as decimal HHMM numbers, countdown ring/snooze
// budgets) and queues that prediction; the monitor pops and compares once
// per cycle shortly after the rising edge.
module tb_aclk_alarm_bank;
    localparam int NA = 4;
    localparam int SN = 5;
    localparam int RM = 10;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_new_a = 1'b0;
    logic [SW-1:0] load_slot = '0;
    logic          load_arm = 1'b0;
    logic [3:0]    n_mh = '0, n_lh = '0, n_mm = '0, n_lm = '0;
    logic [3:0]    c_mh = '0, c_lh = '0, c_mm = '0, c_lm = '0;
    logic          minute_tick = 1'b0;
    logic          snooze = 1'b0;
    logic          stop = 1'b0;
    logic [SW-1:0] disp_slot = '0;
    logic          alarm;
    logic [SW-1:0] alarm_id;
    logic          load_err;
    logic [3:0]    d_mh, d_lh, d_mm, d_lm;
    logic          disp_armed;

    aclk_alarm_bank #(.NUM_ALARMS(NA), .SNOOZE_MIN(SN), .RING_MIN(RM)) dut (
        .clk(clk), .reset(reset), .load_new_a(load_new_a), .load_slot(load_slot),
        .load_arm(load_arm), .new_alarm_ms_hr(n_mh), .new_alarm_ls_hr(n_lh),
        .new_alarm_ms_min(n_mm), .new_alarm_ls_min(n_lm), .cur_ms_hr(c_mh),
        .cur_ls_hr(c_lh), .cur_ms_min(c_mm), .cur_ls_min(c_lm),
        .minute_tick(minute_tick), .snooze(snooze), .stop(stop),
        .disp_slot(disp_slot), .alarm(alarm), .alarm_id(alarm_id),
        .load_err(load_err), .disp_ms_hr(d_mh), .disp_ls_hr(d_lh),
        .disp_ms_min(d_mm), .disp_ls_min(d_lm), .disp_armed(disp_armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int alarm;
        int id;
        int lerr;
        int disp;
        int darm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_time[NA];
    int m_arm[NA];
    int m_mode;       // 0 quiet, 1 ringing, 2 snoozing
    int m_id;
    int ring_left;
    int snz_left;

    function automatic int hhmm(input int a, input int b, input int c, input int d);
        return a * 1000 + b * 100 + c * 10 + d;
    endfunction

    function automatic int legal(input int a, input int b, input int c, input int d);
        int hours;
        hours = a * 10 + b;
        return (a <= 9 && b <= 9 && c <= 5 && d <= 9 && hours <= 23) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_time[i] = 0;
            m_arm[i]  = 0;
        end
        m_mode = 0; m_id = 0; ring_left = 0; snz_left = 0;
    endtask

    // Predict the post-edge outputs for the inputs currently applied,
    // queue them, then advance to the next falling edge and drop pulses.
    task automatic step();
        exp_t e;
        int   cur;
        int   hit;
        cur    = hhmm(c_mh, c_lh, c_mm, c_lm);
        e.disp = m_time[disp_slot];
        e.darm = m_arm[disp_slot];
        e.lerr = (load_new_a && !legal(n_mh, n_lh, n_mm, n_lm)) ? 1 : 0;
        if (m_mode == 0) begin
            if (minute_tick) begin
                hit = -1;
                for (int i = 0; i < NA; i++)
                    if (hit < 0 && m_arm[i] != 0 && m_time[i] == cur) hit = i;
                if (hit >= 0) begin
                    m_mode = 1; m_id = hit; ring_left = RM;
                end
            end
        end else if (stop) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (snooze) begin
                m_mode = 2; snz_left = SN;
            end else if (minute_tick) begin
                ring_left--;
                if (ring_left == 0) m_mode = 0;
            end
        end else if (minute_tick) begin
            snz_left--;
            if (snz_left == 0) begin
                m_mode = 1; ring_left = RM;
            end
        end
        if (load_new_a && legal(n_mh, n_lh, n_mm, n_lm)) begin
            m_time[load_slot] = hhmm(n_mh, n_lh, n_mm, n_lm);
            m_arm[load_slot]  = load_arm;
        end
        e.alarm = (m_mode == 1) ? 1 : 0;
        e.id    = m_id;
        q.push_back(e);
        @(negedge clk);
        load_new_a = 1'b0; minute_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic do_load(input int s, input int a, input int b, input int c, input int d,
                           input bit arm);
        load_slot = SW'(s); load_arm = arm;
        n_mh = 4'(a); n_lh = 4'(b); n_mm = 4'(c); n_lm = 4'(d);
        load_new_a = 1'b1;
    endtask

    task automatic set_cur(input int v);
        c_mh = 4'(v / 1000); c_lh = 4'((v / 100) % 10);
        c_mm = 4'((v / 10) % 10); c_lm = 4'(v % 10);
    endtask

    task automatic tick_at(input int v);
        set_cur(v);
        minute_tick = 1'b1;
        step();
    endtask

    // Monitor: one queued prediction per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("alarm", int'(alarm), e.alarm);
                chk("alarm_id", int'(alarm_id), e.id);
                chk("load_err", int'(load_err), e.lerr);
                chk("disp_time", hhmm(d_mh, d_lh, d_mm, d_lm), e.disp);
                chk("disp_armed", int'(disp_armed), e.darm);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, expected end before 200us");
        $fatal(1, "watchdog");
    end

    int pool[4] = '{600, 730, 1245, 2359};

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_id", int'(alarm_id), 0);
        chk("rst_load_err", int'(load_err), 0);
        chk("rst_disp", hhmm(d_mh, d_lh, d_mm, d_lm), 0);
        chk("rst_disp_armed", int'(disp_armed), 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic ring and stop
        do_load(1, 0, 7, 3, 0, 1); step();
        tick_at(730);
        step();
        stop = 1'b1; step();
        step();

        // Rejected loads keep the slot, then a legal 23:59 lands
        disp_slot = 2'd3;
        do_load(3, 2, 4, 0, 0, 1); step();
        do_load(3, 1, 2, 6, 0, 1); step();
        step();
        do_load(3, 2, 3, 5, 9, 0); step();
        step(); step();

        // Priority: slot 0 disarmed -> slot 2 wins, then slot 0 re-armed wins
        do_load(0, 0, 6, 0, 0, 1); step();
        do_load(2, 0, 6, 0, 0, 1); step();
        do_load(0, 0, 6, 0, 0, 0); step();
        tick_at(600);
        stop = 1'b1; step();
        do_load(0, 0, 6, 0, 0, 1); step();
        tick_at(600);
        stop = 1'b1; step();

        // Snooze for SN ticks, re-ring, then time out after RM ticks
        tick_at(600);
        snooze = 1'b1; step();
        for (int i = 0; i < SN; i++) begin tick_at(900 + i); step(); end
        for (int i = 0; i < RM; i++) begin tick_at(910 + i); step(); end
        step();

        // stop + snooze together; snooze beats a tick; load+tick same cycle
        tick_at(730);
        stop = 1'b1; snooze = 1'b1; step();
        tick_at(730);
        set_cur(731); snooze = 1'b1; minute_tick = 1'b1; step();
        stop = 1'b1; step();
        do_load(3, 0, 8, 1, 5, 1); tick_at(815);
        step();
        tick_at(815);
        stop = 1'b1; step();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            disp_slot = SW'($urandom_range(0, NA - 1));
            r = $urandom_range(0, 99);
            if (r < 6) begin
                int v;
                v = pool[$urandom_range(0, 3)];
                do_load($urandom_range(0, NA - 1), v / 1000, (v / 100) % 10,
                        (v / 10) % 10, v % 10, $urandom_range(0, 3) != 0);
            end else if (r < 9) begin
                do_load($urandom_range(0, NA - 1), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
            end
            if ($urandom_range(0, 99) < 20) begin
                if ($urandom_range(0, 1) == 1) set_cur(pool[$urandom_range(0, 3)]);
                else set_cur(hhmm($urandom_range(0, 2), $urandom_range(0, 3),
                                  $urandom_range(0, 5), $urandom_range(0, 9)));
                minute_tick = 1'b1;
            end
            if ($urandom_range(0, 99) < 4) snooze = 1'b1;
            if ($urandom_range(0, 99) < 2) stop = 1'b1;
            step();
        end

        // Asynchronous reset while ringing
        disp_slot = 2'd0;
        stop = 1'b1; step();
        do_load(1, 0, 7, 3, 0, 1); step();
        tick_at(730);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_alarm", int'(alarm), 0);
        chk("async_rst_id", int'(alarm_id), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick_at(0);
        step();
        disp_slot = 2'd1; step(); step();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aclk_alarm_bank.md
# aclk_alarm_bank

Multi-slot alarm store and ringer for the alarm clock, replacing the single alarm register. It holds NUM_ALARMS independently armed BCD HH:MM alarm times and rejects invalid BCD loads. It compares the current time against all armed slots on each minute tick. It drives a ringing output with snooze, stop and automatic ring timeout, and sits between the keypad/load logic and the display/sounder.

## Interface
- NUM_ALARMS, 4, number of alarm slots (≥2)
- SNOOZE_MIN, 5, minute ticks spent in snooze before re-ringing (1..15)
- RING_MIN, 10, minute ticks of ringing before automatic stop (1..15)
- SLOT_W, $clog2(NUM_ALARMS), slot index width (derived, not overridden)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- load_new_a  in  1  write request for slot load_slot
- load_slot  in  SLOT_W  target slot of write
- load_arm  in  1  arm bit written with the time (0 = store but disarm)
- new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min  in  4 each  BCD time to write
- cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min  in  4 each  current BCD time
- minute_tick  in  1  one-cycle pulse; cur_* already holds the new minute in that cycle
- snooze  in  1  snooze request pulse
- stop  in  1  stop/cancel pulse
- disp_slot  in  SLOT_W  slot selected for readback
- alarm  out  1  ringing
- alarm_id  out  SLOT_W  slot that caused the current ring/snooze
- load_err  out  1  one-cycle pulse: last load rejected
- disp_ms_hr, disp_ls_hr, disp_ms_min, disp_ls_min  out  4 each  stored time of disp_slot
- disp_armed  out  1  arm bit of disp_slot

## Operation
- Valid time: ms_hr ≤ 2; ls_hr ≤ 9, and ≤ 3 when ms_hr = 2; ms_min ≤ 5; ls_min ≤ 9.
- Load, valid time: slot time and arm bit are written.
- Load, invalid time, or load_slot ≥ NUM_ALARMS: nothing is written and load_err pulses.
- State machine, states IDLE, RING, SNOOZE:
  - IDLE: on minute_tick, find armed slots whose time equals cur_*. If any match → RING; alarm_id = lowest matching index; ring counter cleared.
  - RING: stop → IDLE. Otherwise snooze → SNOOZE, snooze counter cleared. Otherwise on minute_tick the ring counter increments; reaching RING_MIN → IDLE.
  - SNOOZE: stop → IDLE. snooze is ignored. On minute_tick the snooze counter increments; reaching SNOOZE_MIN → RING with the ring counter cleared.
- Matches are evaluated only in IDLE. Matches during RING/SNOOZE are dropped, not queued.
- Simultaneous events:
  - stop beats snooze and minute_tick.
  - snooze beats minute_tick in RING; that tick is not counted.
  - A load coinciding with minute_tick: the compare uses pre-load slot contents.
  - Reloading or disarming the ringing slot does not end the ring.
- Slots stay armed after firing (daily alarm).
- Reset values: all slot times 0, all arm bits 0, state IDLE, counters 0, alarm 0, alarm_id 0, load_err 0, disp_* 0, disp_armed 0.
- Reset mid-ring or mid-snooze returns to IDLE immediately, with alarm 0 asynchronously.

## Timing
- Load: slot updated at the load edge; load_err is high the cycle after the rejected load.
- alarm is registered; it rises the cycle after the minute_tick edge that matched.
- Stop clears alarm the cycle after stop.
- Re-ring goes high the cycle after the SNOOZE_MIN-th tick; timeout drops alarm the cycle after the RING_MIN-th tick.
- alarm = 1 exactly in RING; alarm_id holds through RING and SNOOZE and keeps its value in IDLE.
- disp_* and disp_armed are registered, with 1-cycle latency from disp_slot or from a slot write.

## Structure
- Package aclk_pkg:
  - state enum (IDLE, RING, SNOOZE)
  - BCD digit limit constants
  - packed bcd_hhmm_t struct of four 4-bit digits
- Sub-module aclk_bcd_time_check: combinational HH:MM validity check, also usable by the clock-set path.
- Slot storage is a register array; the match uses NUM_ALARMS parallel comparators and a lowest-index priority encoder.

## Test plan
- Load slot 1 = 07:30 armed; tick with cur 07:30 → alarm=1 next cycle, alarm_id=1. Stop → alarm=0.
- Load 24:00, then 12:60 → load_err pulses each time; readback of the slot unchanged; 23:59 accepted.
- Slots 0 and 2 = 06:00 armed, slot 0 then disarmed via load_arm=0 → ring with alarm_id=2. With both armed → alarm_id=0.
- Ring, snooze, SNOOZE_MIN=5 ticks → alarm low for 5 ticks, re-rings after the 5th. Then 10 ticks with no input → alarm=0.
- Stop and snooze in the same cycle during RING → IDLE. Load a matching slot in the same cycle as the tick → no ring.
- Assert reset while ringing → alarm=0 immediately; all slots disarmed; a tick at 00:00 does not ring.
